ntt_loop_controller: RTL
========================

// Module: ntt_loop_controller
// PURPOSE
// Stage/butterfly sequencer for the radix-2 N=1024 NTT/INTT core. Walks every stage p and
// group k, issues one butterfly per accepted cycle with its two data-memory addresses, and
// drives the k/p/conf inputs of the twiddle-address generator immediately downstream.
// Inserts a configurable drain gap between stages so the butterfly pipeline empties first.
// PARAMETERS
// LOGN          10  log2 of transform length; k is LOGN-1 bits, addresses LOGN bits
// DRAIN_CYCLES  4   idle cycles between stages (0 allowed = back-to-back stages)
// PORTS
// clk       in   1   clock, rising edge
// rst       in   1   asynchronous, active-low reset
// start     in   1   request new transform; sampled only in IDLE
// conf      in   3   mode; 3'b001/3'b100 = NTT, 3'b000 = invalid (start ignored), else INTT
// out_ready in   1   downstream accepts current butterfly
// out_valid out  1   k/p/addr_a/addr_b carry a butterfly
// k         out  9   group index within stage (twiddle generator k)
// p         out  4   stage index = log2(butterfly distance) (twiddle generator p)
// conf_q    out  3   conf latched at start, held until next start
// addr_a    out  10  upper butterfly operand address
// addr_b    out  10  lower operand address = addr_a + 2^p
// busy      out  1   transform in progress
// done      out  1   single-cycle pulse after final butterfly accepted
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE; out_valid,busy,done=0; k,addr_a,addr_b,conf_q=0; p=0.
// - All outputs registered. States IDLE, RUN, DRAIN, DONE.
// - IDLE: start=1 and conf!=0 -> latch conf_q, set mode, p=9 (NTT) or 0 (INTT), k=0, i=0,
//   go RUN; busy=1 and out_valid=1 the following cycle (1-cycle start latency).
// - Stage p: m=2^(9-p) groups k=0..m-1 (outer), i=0..2^p-1 (inner); 512 butterflies/stage.
//   addr_a = k*2^(p+1) + i; addr_b = addr_a + 2^p; always fits 10 bits, no wrap.
// - RUN: out_valid=1. Advance only on out_valid&out_ready; otherwise all outputs hold stable.
//   i increments; at i=2^p-1, i=0 and k increments; at k=m-1 and i=2^p-1 the stage ends.
// - Stage end, not last: DRAIN_CYCLES>0 -> DRAIN, out_valid=0 for exactly DRAIN_CYCLES cycles,
//   then RUN with next p (NTT p-1, INTT p+1), k=i=0. DRAIN_CYCLES=0 -> next stage's first
//   butterfly presented the very next cycle.
// - Last stage (NTT p=0, INTT p=9) end -> DONE: done=1, busy=0, out_valid=0 for one cycle; -> IDLE.
// - k/p/addr hold their last values in DRAIN, DONE, IDLE (only out_valid qualifies them).
// - start while busy or in DONE: ignored. conf changes mid-run: ignored (conf_q used).
// - out_ready low during DRAIN/IDLE: no effect. Reset mid-run: immediate IDLE, no done pulse.
// - With out_ready=1 constant, start at cycle 0 -> done at cycle 1 + 5120 + 9*DRAIN_CYCLES.
// TESTING
// 1 NTT conf=001, ready=1, D=4: cycles 1..512 p=9,k=0,addr_a=i,addr_b=i+512; done pulse at 5157.
// 2 NTT stage p=8: k=0 then 1, addr_a=k*512+i, addr_b=addr_a+256; 4 valid-low cycles before it.
// 3 NTT last stage p=0: k=0..511, addr_a=2k, addr_b=2k+1; then done=1 one cycle, busy falls.
// 4 INTT conf=010: first beat p=0,k=0,addr 0/1; last beat p=9,k=0,addr 511/1023; conf_q=010.
// 5 Backpressure: drop out_ready for 3 cycles mid-stage -> outputs frozen, no beat lost or
//   duplicated; start and conf=000 pulses during run ignored; start with conf=000 in IDLE ignored.
// 6 Drive rst=0 at beat 700 -> async clear to reset values, no done; new start runs normally.

Source files
------------

// File: rtl/ntt_loop_controller.sv
// Stage/butterfly sequencer for a radix-2 NTT/INTT core: walks stages and groups,
// issues one butterfly address pair per accepted beat and inserts drain gaps between stages.
module ntt_loop_controller #(
  parameter int unsigned LOGN         = 10,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      conf,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [LOGN-2:0] k,
  output logic [3:0]      p,
  output logic [2:0]      conf_q,
  output logic [LOGN-1:0] addr_a,
  output logic [LOGN-1:0] addr_b,
  output logic            busy,
  output logic            done
);

  localparam int unsigned KW = LOGN - 1;
  localparam int unsigned AW = LOGN;
  localparam int unsigned PW = 4;
  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] p_q, p_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] i_q, i_d;
  logic          intt_q, intt_d;
  logic [2:0]    conf_lat_q, conf_lat_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [AW-1:0] addr_a_q, addr_a_d;
  logic [AW-1:0] addr_b_q, addr_b_d;

  // Butterfly distance 2^p.
  function automatic logic [AW-1:0] span(input logic [PW-1:0] pp);
    return AW'(1) << pp;
  endfunction

  // Upper operand address: group base k*2^(p+1) plus offset i.
  function automatic logic [AW-1:0] calc_addr(input logic [KW-1:0] kk,
                                               input logic [KW-1:0] ii,
                                               input logic [PW-1:0] pp);
    return (AW'(kk) << (pp + PW'(1))) + AW'(ii);
  endfunction

  logic [KW-1:0] i_max;
  logic [KW-1:0] k_max;
  logic [KW-1:0] i_nx;
  logic [KW-1:0] k_nx;
  logic [PW-1:0] p_next;
  logic [PW-1:0] p_start;
  logic          start_intt;
  logic          stage_end;
  logic          last_stage;
  logic          fire;

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    k_d        = k_q;
    i_d        = i_q;
    intt_d     = intt_q;
    conf_lat_d = conf_lat_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    drain_d    = drain_q;
    addr_a_d   = addr_a_q;
    addr_b_d   = addr_b_q;

    // Loop bounds wrap to all-ones when the shift reaches KW (2^9 - 1 = 511).
    i_max      = (KW'(1) << p_q) - KW'(1);
    k_max      = (KW'(1) << (PW'(LOGN - 1) - p_q)) - KW'(1);
    stage_end  = (i_q == i_max) && (k_q == k_max);
    last_stage = intt_q ? (p_q == PW'(LOGN - 1)) : (p_q == PW'(0));
    p_next     = intt_q ? (p_q + PW'(1)) : (p_q - PW'(1));
    fire       = valid_q && out_ready;
    start_intt = !((conf == 3'b001) || (conf == 3'b100));
    p_start    = start_intt ? PW'(0) : PW'(LOGN - 1);

    if (i_q == i_max) begin
      i_nx = '0;
      k_nx = k_q + KW'(1);
    end else begin
      i_nx = i_q + KW'(1);
      k_nx = k_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start && (conf != 3'b000)) begin
          intt_d     = start_intt;
          conf_lat_d = conf;
          p_d        = p_start;
          k_d        = '0;
          i_d        = '0;
          addr_a_d   = '0;
          addr_b_d   = span(p_start);
          valid_d    = 1'b1;
          busy_d     = 1'b1;
          state_d    = S_RUN;
        end
      end

      S_RUN: begin
        if (fire) begin
          if (stage_end) begin
            if (last_stage) begin
              valid_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_DONE;
            end else if (DRAIN_CYCLES > 0) begin
              valid_d = 1'b0;
              drain_d = '0;
              state_d = S_DRAIN;
            end else begin
              p_d      = p_next;
              k_d      = '0;
              i_d      = '0;
              addr_a_d = '0;
              addr_b_d = span(p_next);
            end
          end else begin
            i_d      = i_nx;
            k_d      = k_nx;
            addr_a_d = calc_addr(k_nx, i_nx, p_q);
            addr_b_d = calc_addr(k_nx, i_nx, p_q) + span(p_q);
          end
        end
      end

      // k/p/addr keep their last values while the butterfly pipeline empties.
      S_DRAIN: begin
        if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
          p_d      = p_next;
          k_d      = '0;
          i_d      = '0;
          addr_a_d = '0;
          addr_b_d = span(p_next);
          valid_d  = 1'b1;
          state_d  = S_RUN;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      p_q        <= '0;
      k_q        <= '0;
      i_q        <= '0;
      intt_q     <= 1'b0;
      conf_lat_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drain_q    <= '0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      k_q        <= k_d;
      i_q        <= i_d;
      intt_q     <= intt_d;
      conf_lat_q <= conf_lat_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      drain_q    <= drain_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
    end
  end

  assign out_valid = valid_q;
  assign k         = k_q;
  assign p         = p_q;
  assign conf_q    = conf_lat_q;
  assign addr_a    = addr_a_q;
  assign addr_b    = addr_b_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
